// File: rtl/dispatch_ctrl.sv
// Two-way in-order dispatch scheduler: pops up to two queue entries per cycle into a registered
// dispatch stage, gated by ALU/MEM reservation-station credits, ROB space and one branch per group.
module dispatch_ctrl #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned ALU_RS_DEPTH = 8,
  parameter int unsigned MEM_RS_DEPTH = 4,
  parameter int unsigned ROB_DEPTH    = 16,
  localparam int unsigned AW = $clog2(ALU_RS_DEPTH) + 1,
  localparam int unsigned MW = $clog2(MEM_RS_DEPTH) + 1,
  localparam int unsigned RW = $clog2(ROB_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             q_empty,
  input  logic             q_almost_empty,
  input  logic [WIDTH-1:0] q_data_0,
  input  logic [WIDTH-1:0] q_data_1,
  output logic             q_deq_0,
  output logic             q_deq_1,
  input  logic [RW-1:0]    rob_free,
  input  logic [1:0]       alu_release,
  input  logic [1:0]       mem_release,
  output logic             disp_valid_0,
  output logic             disp_valid_1,
  output logic [WIDTH-1:0] disp_data_0,
  output logic [WIDTH-1:0] disp_data_1,
  output logic [AW-1:0]    alu_credit,
  output logic [MW-1:0]    mem_credit,
  output logic             credit_err
);

  localparam logic [AW:0] AluMax = (AW + 1)'(ALU_RS_DEPTH);
  localparam logic [MW:0] MemMax = (MW + 1)'(MEM_RS_DEPTH);

  logic             is_mem0, is_mem1, is_br0, is_br1;
  logic             slot0_ok, slot1_ok, go0, go1;
  logic [AW:0]      alu_used, alu_sum;
  logic [MW:0]      mem_used, mem_sum;
  logic             alu_ovf, mem_ovf;

  logic [AW-1:0]    alu_credit_q, alu_credit_d;
  logic [MW-1:0]    mem_credit_q, mem_credit_d;
  logic             credit_err_q, credit_err_d;
  logic             valid0_q, valid0_d, valid1_q, valid1_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;

  assign is_mem0 = (q_data_0[1:0] == 2'b01);
  assign is_mem1 = (q_data_1[1:0] == 2'b01);
  assign is_br0  = (q_data_0[1:0] == 2'b10);
  assign is_br1  = (q_data_1[1:0] == 2'b10);

  // Slot 1 needs one more credit than slot 0 consumes from the same pool.
  assign slot0_ok = is_mem0 ? (mem_credit_q != '0) : (alu_credit_q != '0);
  assign slot1_ok = is_mem1 ? (mem_credit_q > MW'(is_mem0)) : (alu_credit_q > AW'(!is_mem0));

  assign go0 = !rst && !flush && !stall && !q_empty && (rob_free != '0) && slot0_ok;
  assign go1 = go0 && !q_almost_empty && (rob_free > RW'(1)) && slot1_ok && !(is_br0 && is_br1);

  assign q_deq_0 = go0;
  assign q_deq_1 = go1;

  always_comb begin
    alu_used = (AW + 1)'(go0 && !is_mem0) + (AW + 1)'(go1 && !is_mem1);
    mem_used = (MW + 1)'(go0 && is_mem0) + (MW + 1)'(go1 && is_mem1);
    alu_sum  = {1'b0, alu_credit_q} - alu_used + (AW + 1)'(alu_release);
    mem_sum  = {1'b0, mem_credit_q} - mem_used + (MW + 1)'(mem_release);
    alu_ovf  = (alu_sum > AluMax);
    mem_ovf  = (mem_sum > MemMax);

    alu_credit_d = alu_ovf ? AluMax[AW-1:0] : alu_sum[AW-1:0];
    mem_credit_d = mem_ovf ? MemMax[MW-1:0] : mem_sum[MW-1:0];
    credit_err_d = credit_err_q | alu_ovf | mem_ovf;

    // Flush discards same-cycle releases but keeps the sticky error.
    if (flush) begin
      alu_credit_d = AluMax[AW-1:0];
      mem_credit_d = MemMax[MW-1:0];
      credit_err_d = credit_err_q;
    end

    valid0_d = go0;
    valid1_d = go1;
    data0_d  = go0 ? q_data_0 : data0_q;
    data1_d  = go1 ? q_data_1 : data1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_credit_q <= AluMax[AW-1:0];
      mem_credit_q <= MemMax[MW-1:0];
      credit_err_q <= 1'b0;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
      data0_q      <= '0;
      data1_q      <= '0;
    end else begin
      alu_credit_q <= alu_credit_d;
      mem_credit_q <= mem_credit_d;
      credit_err_q <= credit_err_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
    end
  end

  assign disp_valid_0 = valid0_q;
  assign disp_valid_1 = valid1_q;
  assign disp_data_0  = data0_q;
  assign disp_data_1  = data1_q;
  assign alu_credit   = alu_credit_q;
  assign mem_credit   = mem_credit_q;
  assign credit_err   = credit_err_q;

endmodule
